// File: rtl/adder_acc_if.sv
// rtl/adder_acc_if.sv - operand/result handshake bundle for adder_acc
interface adder_acc_if #(
  parameter int W = 8
);
  logic [2*W:0] ins;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] sm_r;
  logic         sm_zero_r;
  logic         ovf_r;

  modport master (
    output ins, mode, in_valid, out_ready,
    input  in_ready, out_valid, sm_r, sm_zero_r, ovf_r
  );

  modport slave (
    input  ins, mode, in_valid, out_ready,
    output in_ready, out_valid, sm_r, sm_zero_r, ovf_r
  );
endinterface

// File: rtl/adder_acc.sv
// rtl/adder_acc.sv - handshaked add / accumulate / saturate unit with a 1-deep output register
module adder_acc #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_acc_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_ACC = 2'd1,
    MODE_SAT = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  mode_e        mode;

  logic [W+1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W+1:0] sm_q, sm_d;
  logic         zero_q, zero_d;
  logic         vld_q, vld_d;

  logic [W+1:0] xy_sum;
  logic [W+2:0] acc_sum;
  logic [W+1:0] res;
  logic         accept;
  logic         in_ready;

  assign x    = bus.ins[W-1:0];
  assign y    = bus.ins[2*W-1:W];
  assign cin  = bus.ins[2*W];
  assign mode = mode_e'(bus.mode);

  // Ready depends only on the output register state and the consumer, never on ins/mode.
  assign in_ready = ~vld_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  assign xy_sum  = {2'b00, x} + {2'b00, y} + {{(W+1){1'b0}}, cin};
  assign acc_sum = {1'b0, acc_q} + {3'b000, x} + {{(W+2){1'b0}}, cin};

  always_comb begin
    res   = '0;
    acc_d = acc_q;
    ovf_d = ovf_q;
    case (mode)
      MODE_ADD: res = xy_sum;
      MODE_ACC: begin
        res = acc_sum[W+1:0];
        if (accept) begin
          acc_d = acc_sum[W+1:0];
          ovf_d = ovf_q | acc_sum[W+2];
        end
      end
      MODE_SAT: begin
        if (xy_sum[W+1:W] != 2'b00) begin
          res = {2'b00, {W{1'b1}}};
        end else begin
          res = xy_sum;
        end
      end
      MODE_CLR: begin
        res = '0;
        if (accept) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    sm_d   = sm_q;
    zero_d = zero_q;
    vld_d  = vld_q;
    if (accept) begin
      sm_d   = res;
      zero_d = (res == '0);
      vld_d  = 1'b1;
    end else if (bus.out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      sm_q   <= '0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      sm_q   <= sm_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.sm_r      = sm_q;
  assign bus.sm_zero_r = zero_q;
  assign bus.ovf_r     = ovf_q;

endmodule

// File: tb/tb_adder_acc.sv
// tb/tb_adder_acc.sv - self-checking bench for adder_acc against a queue-based arithmetic model
module tb_adder_acc;
  localparam int W    = 8;
  localparam int MOD  = 1 << (W + 2);
  localparam int SMAX = (1 << W) - 1;

  typedef struct {
    int res;
    bit zero;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  adder_acc_if #(.W(W)) bus ();

  adder_acc #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_m    = 0;
  bit   ovf_m    = 1'b0;
  bit   ordy_cur = 1'b1;
  exp_t exp_q[$];

  logic [W+4:0] obs;
  logic [W+4:0] want;
  logic         rdy_want;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_op(input int md, input int x, input int y, input int cin);
    exp_t e;
    int   s;
    case (md)
      0: e.res = x + y + cin;
      1: begin
        s = acc_m + x + cin;
        if (s >= MOD) ovf_m = 1'b1;
        acc_m = s % MOD;
        e.res = acc_m;
      end
      2: begin
        s = x + y + cin;
        e.res = (s > SMAX) ? SMAX : s;
      end
      default: begin
        acc_m = 0;
        ovf_m = 1'b0;
        e.res = 0;
      end
    endcase
    e.zero = (e.res == 0);
    e.ovf  = ovf_m;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit vld, input int md, input int x, input int y, input int cin, input bit ordy);
    bit acc_ok;
    bus.in_valid  = vld;
    bus.mode      = 2'(md);
    bus.ins       = {1'(cin), W'(y), W'(x)};
    bus.out_ready = ordy;
    ordy_cur      = ordy;
    acc_ok = vld && (exp_q.size() == 0 || ordy);
    @(posedge clk);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (acc_ok) model_op(md, x, y, cin);
    @(negedge clk);
  endtask

  function automatic logic [W+4:0] exp_out();
    if (exp_q.size() == 0) return '0;
    return {1'b1, (W+2)'(exp_q[0].res), exp_q[0].zero, exp_q[0].ovf};
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 2'd0;
    bus.ins       = '0;
    rst_n         = 1'b0;
    #3;
    obs = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    step(1, 0, 255, 255, 1, 1);
    obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
    want = exp_out();
    n_checks++;
    if (obs !== want || bus.sm_r !== 10'd511) begin
      n_fail++;
      $display("FAIL add_max: got %h expected %h (sm_r 511)", obs, want);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_acc_wrap();
    int seq_md[7] = '{3, 1, 1, 1, 1, 1, 3};
    int seq_x[7]  = '{0, 255, 255, 255, 255, 4, 0};
    int seq_c[7]  = '{0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(1, seq_md[i], seq_x[i], 0, seq_c[i], 1);
      obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
      want = exp_out();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL acc_wrap[%0d]: got %h expected %h", i, obs, want);
      end
    end
  endtask

  task automatic test_sat();
    int seq_md[4] = '{1, 2, 2, 1};
    int seq_x[4]  = '{37, 200, 10, 0};
    int seq_y[4]  = '{0, 100, 20, 0};
    int seq_c[4]  = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, seq_md[i], seq_x[i], seq_y[i], seq_c[i], 1);
      obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
      want = exp_out();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL sat[%0d]: got %h expected %h", i, obs, want);
      end
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 1, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 5, 6, 0, 0);
      obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
      want = exp_out();
      n_checks++;
      if (obs !== want || bus.sm_r !== 10'd3) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, want);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
    end
    step(1, 0, 5, 6, 0, 1);
    obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
    want = exp_out();
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL pop_refill: got %h expected %h", obs, want);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    step(1, 3, 0, 0, 0, 1);
    step(1, 1, 100, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
    n_checks++;
    if (obs !== '0 || bus.in_ready !== 1'b0 && bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_ready: got %b expected 1", bus.in_ready);
    end
    acc_m = 0;
    ovf_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 5, 0, 0, 1);
    obs  = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
    want = exp_out();
    n_checks++;
    if (obs !== want || bus.sm_r !== 10'd5) begin
      n_fail++;
      $display("FAIL post_reset_acc: got %h expected %h", obs, want);
    end
  endtask

  task automatic test_random();
    int md;
    for (int i = 0; i < 400; i++) begin
      md = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      step($urandom_range(0, 3) != 0, md, $urandom_range(0, SMAX), $urandom_range(0, SMAX),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0);
      rdy_want = (exp_q.size() == 0) || ordy_cur;
      n_checks++;
      if (bus.in_ready !== rdy_want) begin
        n_fail++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready, rdy_want);
      end
      want = exp_out();
      n_checks++;
      if (bus.out_valid !== want[W+4]) begin
        n_fail++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.out_valid, want[W+4]);
      end else if (exp_q.size() != 0) begin
        obs = {bus.out_valid, bus.sm_r, bus.sm_zero_r, bus.ovf_r};
        n_checks++;
        if (obs !== want) begin
          n_fail++;
          $display("FAIL rand_result[%0d]: got %h expected %h", i, obs, want);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_add();
    test_acc_wrap();
    test_sat();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
